adder_self_test: RTL

Built-in exerciser for the 4-bit ripple-carry adder. It acts as the initiating end of the adder's operand/result interface and replaces the switch reader in test builds. A debounced button starts a run that drives all 512 {Cin, OpY, OpX} combinations into the adder and compares each returned {Cout, Sum} against an internally computed expected value. The block reports busy, done, pass, the error count and the index of the first failing vector for the LED/display logic.

---
 rtl/adder_self_test.sv | 136 +++++++++++++
 1 files changed

// File: rtl/adder_self_test.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_self_test : exhaustive 512-vector exerciser for a 4-bit adder      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module adder_self_test #(
   parameter int SETTLE   = 2,
   parameter int DEBOUNCE = 4
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Start,
   output logic [3:0] OpX,
   output logic [3:0] OpY,
   output logic       Cin,
   input  logic [3:0] Sum,
   input  logic       Cout,
   output logic       Busy,
   output logic       Done,
   output logic       Pass,
   output logic [9:0] ErrCount,
   output logic [8:0] FirstFail
);

   localparam int c_dw = $clog2(DEBOUNCE + 1);
   localparam int c_sw = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [c_dw-1:0] c_deb_max    = c_dw'(DEBOUNCE);
   localparam logic [c_dw-1:0] c_deb_last   = c_dw'(DEBOUNCE - 1);
   localparam logic [c_sw-1:0] c_settle_last = c_sw'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          r_state;
   logic [1:0]      r_sync;
   logic [c_dw-1:0] r_deb_cnt;
   logic [8:0]      r_idx;
   logic [c_sw-1:0] r_settle_cnt;

   logic            w_accept;
   logic [4:0]      w_expected;
   logic            w_mismatch;
   logic [9:0]      w_err_next;

   // Accept fires on the edge the run length reaches DEBOUNCE; the counter
   // then saturates so a held button cannot fire again.
   assign w_accept   = r_sync[1] && (r_deb_cnt == c_deb_last);
   assign w_expected = {1'b0, OpX} + {1'b0, OpY} + {4'b0000, Cin};
   assign w_mismatch = ({Cout, Sum} != w_expected);
   assign w_err_next = (w_mismatch && (ErrCount != 10'd512)) ? ErrCount + 10'd1 : ErrCount;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_sync    <= 2'b00;
         r_deb_cnt <= '0;
      end else begin
         r_sync <= {r_sync[0], Start};
         if (!r_sync[1])
            r_deb_cnt <= '0;
         else if (r_deb_cnt != c_deb_max)
            r_deb_cnt <= r_deb_cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_settle_cnt <= '0;
         OpX          <= '0;
         OpY          <= '0;
         Cin          <= 1'b0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         Pass         <= 1'b0;
         ErrCount     <= '0;
         FirstFail    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_idx   <= '0;
                  Busy    <= 1'b1;
                  r_state <= S_APPLY;
               end
            end
            S_APPLY: begin
               {Cin, OpY, OpX} <= r_idx;
               r_settle_cnt    <= '0;
               r_state         <= S_SETTLE;
            end
            S_SETTLE: begin
               if (r_settle_cnt == c_settle_last)
                  r_state <= S_CHECK;
               else
                  r_settle_cnt <= r_settle_cnt + 1'b1;
            end
            S_CHECK: begin
               if (w_mismatch) begin
                  ErrCount <= w_err_next;
                  if (ErrCount == 10'd0)
                     FirstFail <= r_idx;
               end
               if (r_idx == 9'd511) begin
                  Busy    <= 1'b0;
                  Done    <= 1'b1;
                  Pass    <= (w_err_next == 10'd0);
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 9'd1;
                  r_state <= S_APPLY;
               end
            end
            S_DONE: begin
               if (w_accept) begin
                  ErrCount  <= '0;
                  FirstFail <= '0;
                  Done      <= 1'b0;
                  Pass      <= 1'b0;
                  r_idx     <= '0;
                  Busy      <= 1'b1;
                  r_state   <= S_APPLY;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
